// File: rtl/lpc_decoder.sv
// Passive LPC bus sniffer: decodes I/O and memory read/write cycles from LAD/LFRAME#.
// Optional LPC_SYNC_ERR_EN adds lpc_sync_err, pulsed on SYNC error or SYNC timeout.
module lpc_decoder #(
   parameter int unsigned SYNC_TIMEOUT = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  lpc_ad,
   input  logic        lpc_frame,
   output logic [3:0]  lpc_cyctype_dir,
   output logic [31:0] lpc_addr,
   output logic [7:0]  lpc_data,
   output logic        lpc_latch
`ifdef LPC_SYNC_ERR_EN
   ,
   output logic        lpc_sync_err
`endif
);

   localparam int unsigned TmoW = $clog2(SYNC_TIMEOUT + 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(SYNC_TIMEOUT - 1);

   typedef enum logic [2:0] {
      StIdle, StCyctype, StAddr, StData, StTar1, StSync, StTarEnd
   } state_e;

   state_e          state_q, state_d;
   logic [2:0]      nib_q, nib_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic [3:0]      cyc_q, cyc_d;
   logic [31:0]     addr_q, addr_d;
   logic [7:0]      data_q, data_d;
   logic [3:0]      out_cyc_q, out_cyc_d;
   logic [31:0]     out_addr_q, out_addr_d;
   logic [7:0]      out_data_q, out_data_d;
   logic            latch_q;
   logic            commit;

   always_comb begin
      state_d    = state_q;
      nib_d      = nib_q;
      tmo_d      = tmo_q;
      cyc_d      = cyc_q;
      addr_d     = addr_q;
      data_d     = data_q;
      out_cyc_d  = out_cyc_q;
      out_addr_d = out_addr_q;
      out_data_d = out_data_q;
      commit     = 1'b0;

      if (!lpc_frame) begin
         // Frame low overrides any state: START restarts with clean shift registers.
         state_d = StIdle;
         if (lpc_ad == 4'h0) begin
            state_d = StCyctype;
            addr_d  = '0;
            data_d  = '0;
         end
      end else begin
         unique case (state_q)
            StIdle: state_d = StIdle;
            StCyctype: begin
               cyc_d   = lpc_ad;
               nib_d   = lpc_ad[2] ? 3'd7 : 3'd3;
               state_d = lpc_ad[3] ? StIdle : StAddr;
            end
            StAddr: begin
               addr_d = {addr_q[27:0], lpc_ad};
               if (nib_q == 3'd0) begin
                  nib_d   = 3'd1;
                  state_d = cyc_q[1] ? StData : StTar1;
               end else begin
                  nib_d = nib_q - 3'd1;
               end
            end
            StData: begin
               if (nib_q != 3'd0) begin
                  data_d[3:0] = lpc_ad;
                  nib_d       = 3'd0;
               end else begin
                  data_d[7:4] = lpc_ad;
                  nib_d       = 3'd1;
                  if (cyc_q[1]) begin
                     state_d = StTar1;
                  end else begin
                     state_d = StTarEnd;
                     commit  = 1'b1;
                  end
               end
            end
            StTar1: begin
               if (nib_q == 3'd0) begin
                  state_d = StSync;
                  tmo_d   = '0;
               end else begin
                  nib_d = nib_q - 3'd1;
               end
            end
            StSync: begin
               case (lpc_ad)
                  4'h0: begin
                     nib_d = 3'd1;
                     if (cyc_q[1]) begin
                        state_d = StTarEnd;
                        commit  = 1'b1;
                     end else begin
                        state_d = StData;
                     end
                  end
                  4'h5, 4'h6: begin
                     if (tmo_q >= TmoLast) state_d = StIdle;
                     else                  tmo_d   = tmo_q + TmoW'(1);
                  end
                  default: state_d = StIdle;
               endcase
            end
            StTarEnd: begin
               if (nib_q == 3'd0) state_d = StIdle;
               else               nib_d   = nib_q - 3'd1;
            end
            default: state_d = StIdle;
         endcase
      end

      if (commit) begin
         out_cyc_d  = cyc_q;
         out_addr_d = addr_q;
         out_data_d = data_d;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StIdle;
         nib_q      <= '0;
         tmo_q      <= '0;
         cyc_q      <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         out_cyc_q  <= '0;
         out_addr_q <= '0;
         out_data_q <= '0;
         latch_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         nib_q      <= nib_d;
         tmo_q      <= tmo_d;
         cyc_q      <= cyc_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         out_cyc_q  <= out_cyc_d;
         out_addr_q <= out_addr_d;
         out_data_q <= out_data_d;
         latch_q    <= commit;
      end
   end

`ifdef LPC_SYNC_ERR_EN
   logic sync_fail;
   logic sync_err_q;

   always_comb begin
      sync_fail = 1'b0;
      if (lpc_frame && state_q == StSync) begin
         sync_fail = (lpc_ad == 4'hA) ||
                     ((lpc_ad == 4'h5 || lpc_ad == 4'h6) && tmo_q >= TmoLast);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) sync_err_q <= 1'b0;
      else       sync_err_q <= sync_fail;
   end

   assign lpc_sync_err = sync_err_q;
`endif

   assign lpc_cyctype_dir = out_cyc_q;
   assign lpc_addr        = out_addr_q;
   assign lpc_data        = out_data_q;
   assign lpc_latch       = latch_q;

endmodule

// File: tb/tb_lpc_decoder.sv
// Bench for lpc_decoder: transaction-level model builds a per-clock expectation list,
// then one process drives each nibble and checks the outputs after the edge.
module tb_lpc_decoder;

   localparam int unsigned SyncTimeout = 32;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  lpc_ad;
   logic        lpc_frame;
   logic [3:0]  lpc_cyctype_dir;
   logic [31:0] lpc_addr;
   logic [7:0]  lpc_data;
   logic        lpc_latch;
`ifdef LPC_SYNC_ERR_EN
   logic        lpc_sync_err;
`endif

   always #5 clock = ~clock;

   lpc_decoder #(.SYNC_TIMEOUT(SyncTimeout)) dut (
      .clock           (clock),
      .reset           (reset),
      .lpc_ad          (lpc_ad),
      .lpc_frame       (lpc_frame),
      .lpc_cyctype_dir (lpc_cyctype_dir),
      .lpc_addr        (lpc_addr),
      .lpc_data        (lpc_data),
`ifdef LPC_SYNC_ERR_EN
      .lpc_sync_err    (lpc_sync_err),
`endif
      .lpc_latch       (lpc_latch)
   );

   typedef struct {
      bit          rst;
      logic        frame;
      logic [3:0]  ad;
      bit          latch;
      bit          err;
      logic [3:0]  cyc;
      logic [31:0] addr;
      logic [7:0]  data;
      bit          pin;
      logic [3:0]  pin_cyc;
      logic [31:0] pin_addr;
      logic [7:0]  pin_data;
   } step_t;

   step_t steps[$];
   int    checks = 0;
   int    errors = 0;
   int    last_latch = 0;
   int    cur = 0;

   function automatic step_t mk(input logic fr, input logic [3:0] ad);
      step_t s;
      s = '{default: '0};
      s.frame = fr;
      s.ad    = ad;
      return s;
   endfunction

   task automatic push(input step_t s);
      steps.push_back(s);
      if (s.latch) last_latch = steps.size() - 1;
   endtask

   task automatic push_rst();
      step_t s;
      s = mk(1'($urandom), 4'($urandom));
      s.rst = 1'b1;
      push(s);
   endtask

   // Literal pin on a given step: outputs visible after that step must equal these constants.
   task automatic pin_at(input int idx, input logic [3:0] c, input logic [31:0] a,
                         input logic [7:0] d);
      step_t s;
      s = steps[idx];
      s.pin      = 1'b1;
      s.pin_cyc  = c;
      s.pin_addr = a;
      s.pin_data = d;
      steps[idx] = s;
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) push(mk(1'b1, 4'($urandom)));
   endtask

   // One LPC cycle. se: 0 ready, 1 error code, 2 other code. cut>0 truncates to cut steps.
   task automatic gen_cycle(input bit mem, input bit wr, input logic [31:0] a,
                            input logic [7:0] d, input int waits, input int se,
                            input int cut, input int tar_n, input bit junk,
                            output bit dirty);
      step_t       tmp[$];
      step_t       s;
      logic [3:0]  cyc;
      logic [31:0] ea;
      logic [3:0]  oc;
      bit          done;
      bit          latched;
      int          full;
      cyc     = {1'b0, mem, wr, 1'b0};
      ea      = mem ? a : {16'h0, a[15:0]};
      done    = 1'b0;
      latched = 1'b0;
      if (junk) push(mk(1'b0, 4'($urandom)));
      tmp.push_back(mk(1'b0, 4'h0));
      tmp.push_back(mk(1'b1, cyc));
      for (int i = (mem ? 7 : 3); i >= 0; i--) tmp.push_back(mk(1'b1, a[4*i +: 4]));
      if (wr) begin
         tmp.push_back(mk(1'b1, d[3:0]));
         tmp.push_back(mk(1'b1, d[7:4]));
      end
      tmp.push_back(mk(1'b1, 4'($urandom)));
      tmp.push_back(mk(1'b1, 4'($urandom)));
      for (int w = 0; w < waits && !done; w++) begin
         s = mk(1'b1, ($urandom_range(0, 1) != 0) ? 4'h5 : 4'h6);
         if (w == SyncTimeout - 1) begin
            s.err = 1'b1;
            done  = 1'b1;
         end
         tmp.push_back(s);
      end
      if (!done) begin
         if (se == 1) begin
            s = mk(1'b1, 4'hA);
            s.err = 1'b1;
            tmp.push_back(s);
         end else if (se == 2) begin
            do oc = 4'($urandom);
            while (oc == 4'h0 || oc == 4'h5 || oc == 4'h6 || oc == 4'hA);
            tmp.push_back(mk(1'b1, oc));
         end else begin
            s = mk(1'b1, 4'h0);
            if (!wr) begin
               tmp.push_back(s);
               tmp.push_back(mk(1'b1, d[3:0]));
               s = mk(1'b1, d[7:4]);
            end
            s.latch = 1'b1;
            s.cyc   = cyc;
            s.addr  = ea;
            s.data  = d;
            tmp.push_back(s);
            latched = 1'b1;
         end
      end
      full  = tmp.size();
      dirty = (cut > 0 && cut < full);
      if (dirty) begin
         while (tmp.size() > cut) void'(tmp.pop_back());
      end
      foreach (tmp[i]) push(tmp[i]);
      if (latched && !dirty) gap(tar_n);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d actual=%h required=%h", nm, cur, act, exp);
      end
   endtask

   initial begin
      bit dirty;
      int r;
      reset     = 1'b1;
      lpc_frame = 1'b1;
      lpc_ad    = 4'h0;

      // Directed scenarios.
      push_rst(); push_rst(); push_rst();
      pin_at(steps.size() - 1, 4'h0, 32'h0, 8'h00);
      gap(2);
      gen_cycle(0, 1, 32'h0080, 8'h5A, 0, 0, 0, 2, 0, dirty);
      pin_at(last_latch, 4'h2, 32'h0000_0080, 8'h5A);
      gap(1);
      gen_cycle(1, 0, 32'hFFFF_FFF0, 8'hC3, 3, 0, 0, 2, 0, dirty);
      pin_at(last_latch, 4'h4, 32'hFFFF_FFF0, 8'hC3);
      gen_cycle(0, 1, 32'hBEEF, 8'h11, 0, 0, 4, 0, 0, dirty);
      push(mk(1'b0, 4'hF));
      gap(2);
      gen_cycle(0, 0, 32'h1234, 8'h99, 1, 0, 0, 2, 0, dirty);
      pin_at(last_latch, 4'h0, 32'h0000_1234, 8'h99);
      gen_cycle(0, 0, 32'h0060, 8'h42, SyncTimeout, 0, 0, 2, 0, dirty);
      push(mk(1'b1, 4'h0)); push(mk(1'b1, 4'h3)); push(mk(1'b1, 4'hC));
      pin_at(steps.size() - 1, 4'h0, 32'h0000_1234, 8'h99);
      push(mk(1'b0, 4'h0)); push(mk(1'b1, 4'h8));
      gap(6);
      gen_cycle(0, 1, 32'h1234, 8'h77, 0, 0, 7, 0, 0, dirty);
      push_rst();
      pin_at(steps.size() - 1, 4'h0, 32'h0, 8'h00);
      gen_cycle(0, 1, 32'h03F8, 8'h41, 0, 0, 0, 2, 0, dirty);
      pin_at(last_latch, 4'h2, 32'h0000_03F8, 8'h41);
      gen_cycle(0, 0, 32'h0070, 8'h00, 0, 1, 0, 2, 0, dirty);
      gap(2);
      gen_cycle(0, 1, 32'h02F8, 8'h3C, 0, 0, 0, 0, 0, dirty);
      gen_cycle(0, 1, 32'h002E, 8'hA5, 0, 0, 0, 1, 0, dirty);
      pin_at(last_latch, 4'h2, 32'h0000_002E, 8'hA5);
      gap(2);

      // Randomized traffic.
      dirty = 1'b0;
      for (int t = 0; t < 250; t++) begin
         r = $urandom_range(0, 99);
         if (r < 5) begin
            push(mk(1'b0, 4'h0));
            push(mk(1'b1, {1'b1, 3'($urandom)}));
            dirty = 1'b0;
         end else if (r < 8) begin
            push_rst();
            dirty = 1'b0;
         end else begin
            gen_cycle($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, $urandom,
                      8'($urandom),
                      ($urandom_range(0, 99) < 85) ? $urandom_range(0, 3)
                                                   : $urandom_range(SyncTimeout - 2,
                                                                    SyncTimeout + 3),
                      ($urandom_range(0, 19) == 0) ? 1 : ($urandom_range(0, 19) == 0) ? 2 : 0,
                      ($urandom_range(0, 7) == 0) ? $urandom_range(1, 20) : 0,
                      $urandom_range(0, 2), $urandom_range(0, 7) == 0, dirty);
         end
         if (dirty && $urandom_range(0, 1) != 0) begin
            push(mk(1'b0, 4'hF));
            dirty = 1'b0;
         end
         if (!dirty) begin
            gap($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) push(mk(1'b0, 4'($urandom_range(1, 15))));
         end
      end
      push(mk(1'b0, 4'hF));
      gap(3);

      // Drive and check, with the model's held output values.
      begin
         logic [3:0]  h_cyc;
         logic [31:0] h_addr;
         logic [7:0]  h_data;
         h_cyc  = '0;
         h_addr = '0;
         h_data = '0;
         foreach (steps[i]) begin
            step_t s;
            s   = steps[i];
            cur = i;
            @(negedge clock);
            reset     = s.rst;
            lpc_frame = s.frame;
            lpc_ad    = s.ad;
            @(posedge clock);
            #1;
            if (s.rst) begin
               h_cyc  = '0;
               h_addr = '0;
               h_data = '0;
            end else if (s.latch) begin
               h_cyc  = s.cyc;
               h_addr = s.addr;
               h_data = s.data;
            end
            chk("latch", 32'(lpc_latch), 32'(s.latch && !s.rst));
            chk("cyctype_dir", 32'(lpc_cyctype_dir), 32'(h_cyc));
            chk("addr", lpc_addr, h_addr);
            chk("data", 32'(lpc_data), 32'(h_data));
`ifdef LPC_SYNC_ERR_EN
            chk("sync_err", 32'(lpc_sync_err), 32'(s.err && !s.rst));
`endif
            if (s.pin) begin
               chk("pin_cyctype_dir", 32'(lpc_cyctype_dir), 32'(s.pin_cyc));
               chk("pin_addr", lpc_addr, s.pin_addr);
               chk("pin_data", 32'(lpc_data), 32'(s.pin_data));
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
